// File: rtl/grayscale_histogram_ise.sv
// grayscale_histogram_ise
//   Multi-cycle custom instruction that accumulates a 16-bin luminance
//   histogram from packed 8-bit grayscale words (four pixels per word).
//   Software clears the histogram and reads bins / the pixel total back
//   through the same instruction port.
//
// Ports
//   clock   : system clock, rising edge
//   nReset  : asynchronous active-low reset
//   start   : one-cycle issue strobe from the CPU
//   valueA  : four grayscale bytes for ACCUM (byte 0 = [7:0])
//   valueB  : [1:0] opcode, [5:2] bin index for READBIN
//   iseId   : instruction ID on the shared bus
//   done    : registered one-cycle completion pulse
//   result  : instruction result, zero whenever done is low
//
// state | meaning
// IDLE  | waiting for an issue
// ACC   | incrementing bins/total for byte byte_idx of the latched word
// OP    | single-cycle CLEAR / READBIN / READTOTAL execution
// FIN   | done + result presented; also accepts the next issue
module grayscale_histogram_ise #(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  iseId,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, ACC, OP, FIN} state_t;

  localparam logic [1:0] OP_ACCUM     = 2'd0;
  localparam logic [1:0] OP_CLEAR     = 2'd1;
  localparam logic [1:0] OP_READBIN   = 2'd2;
  localparam logic [1:0] OP_READTOTAL = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] value_a_q, value_a_d;
  logic [1:0]  opcode_q, opcode_d;
  logic [31:0] res_q, res_d;
  logic        done_q, done_d;
  logic [15:0] bin_q [16];
  logic [15:0] bin_d [16];
  logic [31:0] total_q, total_d;

  logic        issue;
  logic [7:0]  pix;
  logic [3:0]  bin_idx;
  logic        unused_value_b;

  assign unused_value_b = ^valueB[31:6];

  // FIN behaves like IDLE for issue sampling so back-to-back instructions
  // are accepted at the edge that ends the FIN cycle.
  assign issue = start && (iseId == customInstructionId) &&
                 ((state_q == IDLE) || (state_q == FIN));

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    value_a_d  = value_a_q;
    opcode_d   = opcode_q;
    res_d      = res_q;
    done_d     = 1'b0;
    bin_d      = bin_q;
    total_d    = total_q;
    pix        = value_a_q[{byte_idx_q, 3'b000} +: 8];
    bin_idx    = pix[7:4];

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (issue) begin
          value_a_d  = valueA;
          opcode_d   = valueB[1:0];
          byte_idx_d = 2'd0;
          // Reads capture the counters as they stand at the issue edge.
          case (valueB[1:0])
            OP_READBIN:   res_d = {16'd0, bin_q[valueB[5:2]]};
            OP_READTOTAL: res_d = total_q;
            default:      res_d = 32'd0;
          endcase
          state_d = (valueB[1:0] == OP_ACCUM) ? ACC : OP;
        end
      end
      ACC: begin
        if (bin_q[bin_idx] != 16'hFFFF) begin
          bin_d[bin_idx] = bin_q[bin_idx] + 16'd1;
        end
        total_d = total_q + 32'd1;
        if (byte_idx_q == 2'd3) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      OP: begin
        if (opcode_q == OP_CLEAR) begin
          for (int i = 0; i < 16; i++) bin_d[i] = 16'd0;
          total_d = 32'd0;
        end
        state_d = FIN;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      byte_idx_q <= 2'd0;
      value_a_q  <= 32'd0;
      opcode_q   <= 2'd0;
      res_q      <= 32'd0;
      done_q     <= 1'b0;
      total_q    <= 32'd0;
      for (int i = 0; i < 16; i++) bin_q[i] <= 16'd0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      value_a_q  <= value_a_d;
      opcode_q   <= opcode_d;
      res_q      <= res_d;
      done_q     <= done_d;
      total_q    <= total_d;
      bin_q      <= bin_d;
    end
  end

  assign done   = done_q;
  assign result = done_q ? res_q : 32'd0;

endmodule

// File: tb/tb_grayscale_histogram_ise.sv
// Randomized self-checking bench for grayscale_histogram_ise with a
// behavioural histogram model (plain integer arrays).
module tb_grayscale_histogram_ise;

  localparam logic [7:0] ID = 8'd0;

  logic        clock = 1'b0;
  logic        nReset;
  logic        start;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic [7:0]  iseId;
  logic        done;
  logic [31:0] result;

  int          n_tests = 0;
  int          n_fail  = 0;

  int          model_bin [16];
  logic [31:0] model_total;

  grayscale_histogram_ise #(.customInstructionId(ID)) dut (
    .clock  (clock),
    .nReset (nReset),
    .start  (start),
    .valueA (valueA),
    .valueB (valueB),
    .iseId  (iseId),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) model_bin[i] = 0;
    model_total = 32'd0;
  endfunction

  function automatic void model_accum(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      int b;
      b = (w >> (8 * k + 4)) & 32'hF;
      if (model_bin[b] < 65535) model_bin[b]++;
      model_total = model_total + 32'd1;
    end
  endfunction

  // Caller is at a negedge; the issue is sampled at the next rising edge.
  // Returns at the negedge where done is observed (or after a timeout).
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [3:0] bin, output logic [31:0] res);
    logic [31:0] b;
    logic [31:0] exp_res;
    int          cyc;
    bit          got;
    b      = $urandom;
    b[1:0] = op;
    b[5:2] = bin;
    case (op)
      2'd2:    exp_res = model_bin[bin];
      2'd3:    exp_res = model_total;
      default: exp_res = 32'd0;
    endcase
    start = 1'b1; iseId = ID; valueA = a; valueB = b;
    @(posedge clock); #1;
    start = 1'b0; valueA = $urandom; valueB = $urandom;
    got = 0; cyc = 0; res = 32'd0;
    while (!got && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (done) begin got = 1; res = result; end
    end
    chk($sformatf("latency op%0d", op), got ? cyc : -1, (op == 2'd0) ? 5 : 2);
    chk($sformatf("result op%0d", op), res, exp_res);
    if (op == 2'd0) model_accum(a);
    if (op == 2'd1) model_clear();
  endtask

  initial begin
    logic [31:0] r;
    int          dones;
    bit          bad;

    nReset = 1'b0; start = 1'b0; valueA = '0; valueB = '0; iseId = ID;
    model_clear();
    bad = 0;
    // Strobe during reset must not produce anything.
    repeat (2) @(negedge clock);
    start = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (done !== 1'b0 || result !== 32'd0) bad = 1;
    end
    start = 1'b0;
    chk("quiet in reset", {31'd0, bad}, 32'd0);
    nReset = 1'b1;
    @(negedge clock);

    do_op(2'd3, 32'd0, 4'd0, r);
    chk("total after reset", r, 32'd0);

    // Directed: one pixel each in bins 0, 4, 8, 15.
    do_op(2'd1, 32'd0, 4'd0, r);
    do_op(2'd0, 32'hF0804000, 4'd0, r);
    do_op(2'd2, 32'd0, 4'd0,  r); chk("bin0",  r, 32'd1);
    do_op(2'd2, 32'd0, 4'd4,  r); chk("bin4",  r, 32'd1);
    do_op(2'd2, 32'd0, 4'd8,  r); chk("bin8",  r, 32'd1);
    do_op(2'd2, 32'd0, 4'd15, r); chk("bin15", r, 32'd1);
    do_op(2'd2, 32'd0, 4'd1,  r); chk("bin1",  r, 32'd0);
    do_op(2'd3, 32'd0, 4'd0,  r); chk("total4", r, 32'd4);

    // Duplicate bins within a word.
    do_op(2'd1, 32'd0, 4'd0, r);
    do_op(2'd0, 32'h1F1F1F1F, 4'd0, r);
    do_op(2'd0, 32'h1F1F1F1F, 4'd0, r);
    do_op(2'd2, 32'd0, 4'd1, r); chk("dup bin1", r, 32'd8);
    do_op(2'd3, 32'd0, 4'd0, r); chk("dup total", r, 32'd8);

    // Foreign ID is ignored.
    start = 1'b1; iseId = 8'h5A; valueB = 32'd1;
    @(negedge clock);
    start = 1'b0; iseId = ID;
    dones = 0;
    repeat (8) begin @(negedge clock); if (done) dones++; end
    chk("foreign id dones", dones, 0);
    do_op(2'd3, 32'd0, 4'd0, r); chk("foreign id total", r, 32'd8);

    // Re-issue during ACC is ignored; exactly one done.
    start = 1'b1; iseId = ID; valueA = 32'h22222222; valueB = 32'd0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1; valueA = 32'hFFFFFFFF; valueB = 32'd1;
    @(negedge clock);
    start = 1'b0;
    dones = 0;
    repeat (10) begin @(negedge clock); if (done) dones++; end
    chk("single done", dones, 1);
    model_accum(32'h22222222);
    do_op(2'd2, 32'd0, 4'd2, r); chk("bin2 after reissue", r, 32'd4);
    do_op(2'd3, 32'd0, 4'd0, r); chk("total after reissue", r, 32'd12);

    // Reset in the middle of an ACCUM.
    start = 1'b1; iseId = ID; valueA = 32'd0; valueB = 32'd0;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    nReset = 1'b0;
    dones = 0;
    repeat (3) begin @(negedge clock); if (done) dones++; end
    nReset = 1'b1;
    repeat (6) begin @(negedge clock); if (done) dones++; end
    chk("no done after reset", dones, 0);
    model_clear();
    do_op(2'd2, 32'd0, 4'd0, r); chk("bin0 after reset", r, 32'd0);
    do_op(2'd3, 32'd0, 4'd0, r); chk("total after midreset", r, 32'd0);

    // Randomized mix against the model.
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  op;
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 9);
      op  = (sel < 5) ? 2'd0 : (sel == 5) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      a   = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'h3F3F3F3F;
      do_op(op, a, 4'($urandom_range(0, 15)), r);
    end
    for (int i = 0; i < 16; i++) do_op(2'd2, 32'd0, 4'(i), r);

    // Saturation of bin 15; total keeps counting.
    do_op(2'd1, 32'd0, 4'd0, r);
    for (int n = 0; n < 16385; n++) do_op(2'd0, 32'hFFFFFFFF, 4'd0, r);
    do_op(2'd2, 32'd0, 4'd15, r); chk("sat bin15", r, 32'h0000FFFF);
    do_op(2'd3, 32'd0, 4'd0,  r); chk("sat total", r, 32'h00010004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
